// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter feeding a single UART transmitter.
// Handshakes with the transmitter through tdre and aborts a load that is never picked up.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic        tx_ready,
    output logic [7:0]  tx_data,
    input  logic        tx_tdre,
    output logic        busy,
    output logic        err
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [1:0]    last, last_nxt;
    logic [3:0]    ack_nxt;
    logic          tx_ready_nxt;
    logic [7:0]    tx_data_nxt;
    logic          busy_nxt;
    logic          err_nxt;

    logic          grant_found;
    logic [1:0]    grant_idx;
    logic [1:0]    cand;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            timer    <= '0;
            last     <= 2'd3;
            ack      <= '0;
            tx_ready <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            last     <= last_nxt;
            ack      <= ack_nxt;
            tx_ready <= tx_ready_nxt;
            tx_data  <= tx_data_nxt;
            busy     <= busy_nxt;
            err      <= err_nxt;
        end
    end

    // Round-robin search starting just after the last winner, wrapping at 4.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last;
        cand        = last;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        last_nxt     = last;
        ack_nxt      = '0;
        tx_ready_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        err_nxt      = err;

        case (state)
            IDLE: begin
                if (tx_tdre && grant_found) begin
                    tx_data_nxt        = req_data[{grant_idx, 3'b000} +: 8];
                    ack_nxt[grant_idx] = 1'b1;
                    last_nxt           = grant_idx;
                    state_nxt          = LOAD;
                end
            end
            LOAD: begin
                tx_ready_nxt = 1'b1;
                timer_nxt    = '0;
                state_nxt    = WAIT_START;
            end
            WAIT_START: begin
                if (!tx_tdre) begin
                    state_nxt = WAIT_DONE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (timer != '1) begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_tdre) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model
// that holds tdre low for ten cycles after each load strobe.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_tdre;
    logic        busy;
    logic        err;

    logic        uart_en;
    logic        man_tdre;
    int          uart_cnt;
    logic [7:0]  tx_log [0:63];
    int          n_tx = 0;

    int total  = 0;
    int passed = 0;

    uart_tx_arbiter #(.TIMEOUT(16)) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_tdre  (tx_tdre),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            uart_cnt <= 0;
        end else if (tx_ready) begin
            uart_cnt <= 10;
        end else if (uart_cnt != 0) begin
            uart_cnt <= uart_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (tx_ready) begin
            tx_log[n_tx % 64] <= tx_data;
            n_tx <= n_tx + 1;
        end
    end

    assign tx_tdre = uart_en ? (uart_cnt == 0) : man_tdre;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int base;
        int viol;
        int ng;
        int ack_cnt [0:3];
        logic [3:0] grants [0:3];

        clr      = 1'b1;
        req      = '0;
        req_data = '0;
        uart_en  = 1'b1;
        man_tdre = 1'b1;
        repeat (2) tick();
        check("rst_ack",      {28'd0, ack},      32'h0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'h0);
        check("rst_tx_data",  {24'd0, tx_data},  32'h0);
        check("rst_busy",     {31'd0, busy},     32'h0);
        check("rst_err",      {31'd0, err},      32'h0);
        clr = 1'b0;
        tick();

        // Single request: ack at +1, strobe at +2, then ten cycles of shifting.
        req      = 4'b0001;
        req_data = 32'h0000_00AA;
        tick();
        check("t1_ack",       {28'd0, ack},      32'h1);
        check("t1_busy",      {31'd0, busy},     32'h1);
        check("t1_noready",   {31'd0, tx_ready}, 32'h0);
        req = '0;
        tick();
        check("t1_ack_clr",   {28'd0, ack},      32'h0);
        check("t1_tx_ready",  {31'd0, tx_ready}, 32'h1);
        check("t1_tx_data",   {24'd0, tx_data},  32'hAA);
        tick();
        check("t1_ready_pulse", {31'd0, tx_ready}, 32'h0);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 40);
        check("t1_done_lat",  n,                 11);
        check("t1_err",       {31'd0, err},      32'h0);

        // All four after reset: served 0,1,2,3 with one ack each.
        clr = 1'b1;
        #2;
        clr = 1'b0;
        tick();
        base     = n_tx;
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        viol     = 0;
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        n = 0;
        while (!((n_tx - base) == 4 && !busy) && n < 300) begin
            tick();
            n++;
            for (int i = 0; i < 4; i++) ack_cnt[i] += int'(ack[i]);
            if ($countones(ack) > 1 || (ack != 0 && tx_ready)) viol++;
            req = req & ~ack;
        end
        check("t2_count",     n_tx - base,       4);
        check("t2_byte0",     {24'd0, tx_log[(base + 0) % 64]}, 32'h11);
        check("t2_byte1",     {24'd0, tx_log[(base + 1) % 64]}, 32'h22);
        check("t2_byte2",     {24'd0, tx_log[(base + 2) % 64]}, 32'h33);
        check("t2_byte3",     {24'd0, tx_log[(base + 3) % 64]}, 32'h44);
        check("t2_acks0",     ack_cnt[0],        1);
        check("t2_acks1",     ack_cnt[1],        1);
        check("t2_acks2",     ack_cnt[2],        1);
        check("t2_acks3",     ack_cnt[3],        1);
        check("t2_onehot",    viol,              0);

        // Requesters 0 and 2 held high: strict alternation.
        req = 4'b0101;
        ng  = 0;
        n   = 0;
        while (ng < 4 && n < 400) begin
            tick();
            n++;
            if (ack != 0) begin
                grants[ng] = ack;
                ng++;
            end
        end
        check("t3_ngrants",   ng,                4);
        check("t3_g0",        {28'd0, grants[0]}, 32'h1);
        check("t3_g1",        {28'd0, grants[1]}, 32'h4);
        check("t3_g2",        {28'd0, grants[2]}, 32'h1);
        check("t3_g3",        {28'd0, grants[3]}, 32'h4);
        req = '0;
        wait_idle("t3_idle");

        // tdre never falls: err exactly 16 cycles after the strobe.
        tick();
        uart_en  = 1'b0;
        man_tdre = 1'b1;
        req      = 4'b0010;
        req_data = 32'h0000_7700;
        tick();
        check("t4_ack",       {28'd0, ack},      32'h2);
        req = '0;
        tick();
        check("t4_tx_ready",  {31'd0, tx_ready}, 32'h1);
        n = 0;
        do begin
            tick();
            n++;
            if (ack != 0) viol++;
        end while (!err && n < 40);
        check("t4_err_lat",   n,                 16);
        check("t4_idle",      {31'd0, busy},     32'h0);
        check("t4_no_reack",  viol,              0);
        uart_en  = 1'b1;
        req      = 4'b0100;
        req_data = 32'h0099_0000;
        tick();
        check("t4_next_ack",  {28'd0, ack},      32'h4);
        req = '0;
        tick();
        check("t4_next_data", {24'd0, tx_data},  32'h99);
        wait_idle("t4_next_idle");
        check("t4_err_sticky", {31'd0, err},     32'h1);

        // Reset in the middle of a transmission.
        tick();
        req      = 4'b0001;
        req_data = 32'hDD00_00CC;
        tick();
        check("t5_ack",       {28'd0, ack},      32'h1);
        req = '0;
        repeat (4) tick();
        check("t5_busy",      {31'd0, busy},     32'h1);
        clr = 1'b1;
        #1;
        check("t5_clr_ack",   {28'd0, ack},      32'h0);
        check("t5_clr_ready", {31'd0, tx_ready}, 32'h0);
        check("t5_clr_data",  {24'd0, tx_data},  32'h0);
        check("t5_clr_busy",  {31'd0, busy},     32'h0);
        check("t5_clr_err",   {31'd0, err},      32'h0);
        req = 4'b1000;
        tick();
        clr = 1'b0;
        tick();
        check("t5_ack3",      {28'd0, ack},      32'h8);
        req = '0;
        tick();
        check("t5_data3",     {24'd0, tx_data},  32'hDD);
        wait_idle("t5_idle");

        // tdre low in IDLE holds off grants; a dropped request is ignored.
        tick();
        uart_en  = 1'b0;
        man_tdre = 1'b0;
        req      = 4'b0011;
        req_data = 32'h0000_5A3C;
        viol     = 0;
        repeat (3) begin
            tick();
            if (ack != 0 || busy) viol++;
        end
        check("t6_hold",      viol,              0);
        req      = 4'b0010;
        man_tdre = 1'b1;
        tick();
        check("t6_ack",       {28'd0, ack},      32'h2);
        check("t6_data",      {24'd0, tx_data},  32'h5A);
        req = '0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of cycles to wait for tdre to fall after a load before aborting.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req  input  4  per-requester transmit request, level; held until the matching ack.
REQ-005 SHALL have port req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-006 SHALL have port ack  output  4  one-cycle pulse: requester i's byte has been captured.
REQ-007 SHALL have port tx_ready  output  1  load strobe to the UART transmitter's ready input.
REQ-008 SHALL have port tx_data  output  8  byte to the UART transmitter's tx_data input.
REQ-009 SHALL have port tx_tdre  input  1  transmitter's tdre: 1 = idle/empty, 0 = shifting.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, WAIT_START and WAIT_DONE; all outputs are registered.
REQ-013 In IDLE with tx_tdre=1 and req!=0, SHALL pick the winner round-robin, searching from (last+1) mod 4 upward with wrap.
REQ-014 On that edge: tx_data<=winner's byte, ack[winner]<=1 for exactly one cycle, last<=winner, state->LOAD.
REQ-015 In IDLE with tx_tdre=0, SHALL grant nothing and hold state.
REQ-016 LOAD SHALL drive tx_ready=1 for exactly one cycle, clear the timer, then go to WAIT_START.
REQ-017 WAIT_START: tx_tdre=0 -> WAIT_DONE.
REQ-018 WAIT_START: otherwise increment the timer; when the timer reaches TIMEOUT-1, set err=1 and go to IDLE.
REQ-019 WAIT_DONE: tx_tdre=1 -> IDLE; no timeout applies in WAIT_DONE.
REQ-020 tx_data SHALL hold its value from capture until the next capture.
REQ-021 Latency: req seen in IDLE -> ack at +1 cycle -> tx_ready at +1 cycle after ack.
REQ-022 Minimum spacing between successive grants is one full transmission plus 1 IDLE cycle.
REQ-023 A req still high after its ack SHALL be treated as a new request at lower priority behind the others.
REQ-024 A req dropped before grant SHALL be ignored; no ack is issued.
REQ-025 Simultaneous requests from all four after reset SHALL be served in order 0,1,2,3,0.
REQ-026 ack SHALL be one-hot or zero; tx_ready and ack are never high in the same cycle.
REQ-027 err SHALL be sticky until clr.
REQ-028 A timeout SHALL not re-ack; the aborted byte is lost and arbitration resumes from last+1.
REQ-029 The timer SHALL be $clog2(TIMEOUT)+1 bits, saturating, with no wrap.

Reset
REQ-030 While clr=1: state=IDLE, ack=0, tx_ready=0, tx_data=8'h00, busy=0, err=0, timer=0, last=3.
REQ-031 clr asserted mid-transmission SHALL abort immediately with no pending ack or strobe; the first grant after release goes to requester 0 if requesting.

Verification
REQ-032 Reset, req=4'b0001, data0=8'hAA, tdre=1 -> ack=0001 at +1 cycle, tx_ready pulse with tx_data=AA at +2 cycles; model tdre low 10 cycles -> busy then IDLE.
REQ-033 req=4'b1111, bytes 11/22/33/44, UART model toggling tdre -> bytes transmitted in order 11,22,33,44, one ack each.
REQ-034 req0 held continuously with req2 high -> grants alternate 0,2,0,2.
REQ-035 tdre stuck at 1 after load, TIMEOUT=16 -> err=1 exactly 16 cycles after tx_ready; next request is still served; err stays 1.
REQ-036 clr pulsed during WAIT_DONE -> all outputs 0 the same cycle; after release with req=4'b1000 -> ack=1000.
REQ-037 tdre=0 in IDLE with req=4'b0010 -> no ack until tdre=1, then ack=0010 the next cycle.
